cpu_program_sequencer: RTL and testbench
========================================

CPU_PROGRAM_SEQUENCER -- requirements
Module: cpu_program_sequencer

Interface
REQ-001 Parameter: STOP_OPCODE, default 4'b1111, HALT opcode; never issued to the datapath.
REQ-002 Parameter: JMP_OPCODE, default 4'b1110, jump opcode; pc <= operand; never issued.
REQ-003 Parameter: MAX_STEPS, default 64, watchdog limit on issued instructions per run (1..255).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 load_en  input  1  host program write strobe.
REQ-007 load_addr  input  4  program memory write address.
REQ-008 load_instr  input  8  instruction: [7:4] opcode, [3:0] operand.
REQ-009 start  input  1  one-cycle request to run the program from address 0.
REQ-010 abort  input  1  stop the run immediately.
REQ-011 exe_ready  input  1  datapath accepts the current instruction.
REQ-012 exe_valid  output  1  instruction offered to the datapath.
REQ-013 exe_opcode  output  4  opcode offered.
REQ-014 exe_operand  output  4  operand offered.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at the end of a run.
REQ-017 err  output  1  sticky watchdog flag; cleared by the next accepted start.
REQ-018 pc  output  4  current program address.
REQ-019 step_cnt  output  8  instructions issued in the current run.

Function
REQ-020 Program memory: 16 x 8 bits; write on load_en only in IDLE; load_en outside IDLE is ignored.
REQ-021 States: IDLE, FETCH, ISSUE, DONE.
REQ-022 IDLE: start -> FETCH with pc=0, step_cnt=0, err=0; start outside IDLE is ignored.
REQ-023 Same-cycle load_en and start in IDLE: write completes and start is accepted; the first FETCH reads the new data.
REQ-024 FETCH (1 cycle) reads mem[pc]: STOP_OPCODE -> DONE; JMP_OPCODE -> pc<=operand, stay in FETCH; otherwise -> ISSUE.
REQ-025 Back-to-back jumps: each costs 1 cycle and does not count toward step_cnt.
REQ-026 Jump loop guard: 16 consecutive jumps with no issue -> DONE with err=1.
REQ-027 ISSUE: exe_valid=1; exe_opcode/exe_operand stable from the fetched word until handshake.
REQ-028 Handshake: exe_valid and exe_ready high in the same cycle = accepted; step_cnt+1; pc+1 mod 16.
REQ-029 After acceptance: next state is FETCH; exe_valid low for at least 1 cycle between instructions.
REQ-030 exe_ready while exe_valid is low: ignored.
REQ-031 Accept at pc=15: pc wraps to 0 and the run continues.
REQ-032 Watchdog: accept that makes step_cnt == MAX_STEPS -> DONE with err=1 instead of FETCH.
REQ-033 DONE: done=1 for exactly one cycle, then IDLE; pc and step_cnt hold their values until the next start.
REQ-034 abort in FETCH, ISSUE or DONE: IDLE next cycle; exe_valid low; no done pulse; partial handshake discarded; err unchanged.
REQ-035 abort and exe_ready in the same cycle: abort wins; step_cnt not incremented.
REQ-036 Latency: start in cycle N -> exe_valid high in cycle N+2 when mem[0] is an issuable opcode.

Reset
REQ-037 rst: state=IDLE; exe_valid=0, exe_opcode=0, exe_operand=0, busy=0, done=0, err=0, pc=0, step_cnt=0.
REQ-038 rst: every program memory word = {STOP_OPCODE, 4'b0000}.
REQ-039 rst asserted mid-run: outputs take reset values asynchronously; the run is lost; no done pulse.

Verification
REQ-040 Basic run: load 0x05, 0x13, 0xF0 at addr 0..2; start; exe_ready always high -> issues (0,5) then (1,3); done pulse; step_cnt=2; pc=2; err=0.
REQ-041 Backpressure: exe_ready low 5 cycles -> exe_valid and opcode/operand held stable; single accept; step_cnt increments by exactly 1.
REQ-042 Jump loop: addr0=0x21, addr1=0xE0, MAX_STEPS=64 -> 64 issues of (2,1); done with err=1; step_cnt=64.
REQ-043 Pure jump loop: addr0=0xE0 -> DONE after 16 FETCH cycles; err=1; step_cnt=0; no exe_valid.
REQ-044 Abort during ISSUE with exe_ready high the same cycle -> IDLE next cycle; no done; step_cnt unchanged.
REQ-045 Reset then start with no load -> first FETCH sees HALT; done pulse in cycle N+2; no exe_valid; step_cnt=0.

Source files
------------

// File: rtl/cpu_program_sequencer.sv
// Program sequencer: host-loaded 16x8 program memory and a fetch/issue FSM that
// hands instructions to a datapath over a valid/ready handshake.
module cpu_program_sequencer #(
  parameter logic [3:0] STOP_OPCODE = 4'b1111,
  parameter logic [3:0] JMP_OPCODE  = 4'b1110,
  parameter int         MAX_STEPS   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_en,
  input  logic [3:0] load_addr,
  input  logic [7:0] load_instr,
  input  logic       start,
  input  logic       abort,
  input  logic       exe_ready,
  output logic       exe_valid,
  output logic [3:0] exe_opcode,
  output logic [3:0] exe_operand,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] pc,
  output logic [7:0] step_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;

  localparam logic [7:0] MAX_STEPS_L = 8'(MAX_STEPS);

  state_t     state, state_nxt;
  logic [7:0] mem [16];
  logic [7:0] fetch_word;
  logic [3:0] jmp_cnt;
  logic       fetch_stop, fetch_jmp, jmp_limit, accept, last_step;

  assign fetch_word = mem[pc];
  assign fetch_stop = (fetch_word[7:4] == STOP_OPCODE);
  assign fetch_jmp  = (fetch_word[7:4] == JMP_OPCODE) && !fetch_stop;
  // jmp_cnt counts jumps already taken since the last issue; the 16th trips the guard
  assign jmp_limit  = (jmp_cnt == 4'd15);
  assign accept     = (state == ISSUE) && exe_ready && !abort;
  assign last_step  = ((step_cnt + 8'd1) == MAX_STEPS_L);

  assign exe_valid  = (state == ISSUE);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE) && !abort;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: begin
        if (abort)          state_nxt = IDLE;
        else if (fetch_stop) state_nxt = DONE;
        else if (fetch_jmp)  state_nxt = jmp_limit ? DONE : FETCH;
        else                 state_nxt = ISSUE;
      end
      ISSUE: begin
        if (abort)          state_nxt = IDLE;
        else if (exe_ready) state_nxt = last_step ? DONE : FETCH;
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= 4'd0;
      step_cnt    <= 8'd0;
      err         <= 1'b0;
      jmp_cnt     <= 4'd0;
      exe_opcode  <= 4'd0;
      exe_operand <= 4'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pc       <= 4'd0;
          step_cnt <= 8'd0;
          err      <= 1'b0;
          jmp_cnt  <= 4'd0;
        end
        FETCH: if (!abort && !fetch_stop) begin
          if (fetch_jmp) begin
            if (jmp_limit) begin
              err <= 1'b1;
            end else begin
              pc      <= fetch_word[3:0];
              jmp_cnt <= jmp_cnt + 4'd1;
            end
          end else begin
            exe_opcode  <= fetch_word[7:4];
            exe_operand <= fetch_word[3:0];
          end
        end
        ISSUE: if (accept) begin
          step_cnt <= step_cnt + 8'd1;
          pc       <= pc + 4'd1;
          jmp_cnt  <= 4'd0;
          if (last_step) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Host writes land only while idle, so a same-cycle start fetches the new word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= {STOP_OPCODE, 4'b0000};
    end else if (load_en && (state == IDLE)) begin
      mem[load_addr] <= load_instr;
    end
  end

endmodule

// File: tb/tb_cpu_program_sequencer.sv
// Bench for cpu_program_sequencer: directed scenarios plus random programs with
// random backpressure, checked against an instruction-level interpreter.
module tb_cpu_program_sequencer;

  localparam logic [3:0] STOP = 4'hF;
  localparam logic [3:0] JMP  = 4'hE;
  localparam int         MAXS = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_en = 1'b0;
  logic [3:0] load_addr = 4'd0;
  logic [7:0] load_instr = 8'd0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       exe_ready = 1'b0;
  logic       exe_valid, busy, done, err;
  logic [3:0] exe_opcode, exe_operand, pc;
  logic [7:0] step_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] tb_mem [16];
  logic [7:0] exp_q [$];
  logic [3:0] exp_pc;
  logic [7:0] exp_steps;
  logic       exp_err;

  cpu_program_sequencer #(.STOP_OPCODE(STOP), .JMP_OPCODE(JMP), .MAX_STEPS(MAXS)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_instr(load_instr), .start(start), .abort(abort), .exe_ready(exe_ready),
    .exe_valid(exe_valid), .exe_opcode(exe_opcode), .exe_operand(exe_operand),
    .busy(busy), .done(done), .err(err), .pc(pc), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  // Interpreter: walks the program as an instruction stream, no cycle detail.
  task automatic model_run();
    int p = 0, steps = 0, jmps = 0;
    logic [7:0] w;
    exp_q.delete();
    exp_err = 1'b0;
    while (1) begin
      w = tb_mem[p];
      if (w[7:4] == STOP) break;
      if (w[7:4] == JMP) begin
        jmps++;
        if (jmps == 16) begin exp_err = 1'b1; break; end
        p = int'(w[3:0]);
        continue;
      end
      exp_q.push_back(w);
      steps++;
      jmps = 0;
      p = (p + 1) % 16;
      if (steps == MAXS) begin exp_err = 1'b1; break; end
    end
    exp_pc = 4'(p);
    exp_steps = 8'(steps);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 0; abort = 0; load_en = 0; exe_ready = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) tb_mem[i] = {STOP, 4'h0};
  endtask

  task automatic load_word(input logic [3:0] a, input logic [7:0] w);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_instr = w;
    @(negedge clk);
    load_en = 1'b0;
    tb_mem[a] = w;
  endtask

  task automatic run_prog(input int ready_pct, output int done_cyc, output int first_valid);
    logic [7:0] got [$];
    logic [7:0] prev_word;
    bit prev_stall, prev_acc, seen_done, bad;
    int i;
    model_run();
    @(negedge clk);
    start = 1'b1;
    i = 0; done_cyc = -1; first_valid = -1;
    prev_stall = 0; prev_acc = 0; seen_done = 0; prev_word = 8'h00;
    while (i < 3000 && !seen_done) begin
      @(negedge clk);
      i++;
      start = 1'b0;
      if (done) begin
        seen_done = 1; done_cyc = i; exe_ready = 1'b0;
      end else begin
        if (exe_valid && first_valid < 0) first_valid = i;
        if (prev_stall) begin
          checks++;
          if (!exe_valid || {exe_opcode, exe_operand} !== prev_word) begin
            errors++;
            $display("FAIL hold_stable: got valid=%0b word=%h, need valid=1 word=%h", exe_valid, {exe_opcode, exe_operand}, prev_word);
          end
        end
        if (prev_acc) begin
          checks++;
          if (exe_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_gap: got exe_valid=%0b after accept, need 0", exe_valid);
          end
        end
        exe_ready = ($urandom_range(0, 99) < ready_pct);
        if (exe_valid && exe_ready) got.push_back({exe_opcode, exe_operand});
        prev_stall = exe_valid && !exe_ready;
        prev_acc = exe_valid && exe_ready;
        prev_word = {exe_opcode, exe_operand};
      end
    end
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL run_timeout: got no done within 3000 cycles, need done");
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL after_done: got busy=%0b done=%0b, need 0 0", busy, done);
    end
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL issue_count: got %0d issues, need %0d", got.size(), exp_q.size());
    end
    bad = 0;
    for (int k = 0; k < got.size() && k < exp_q.size(); k++)
      if (got[k] !== exp_q[k]) bad = 1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL issue_seq: issued words differ from interpreter order");
    end
    checks++;
    if (step_cnt !== exp_steps || pc !== exp_pc || err !== exp_err) begin
      errors++;
      $display("FAIL final_state: got step=%0d pc=%0d err=%0b, need step=%0d pc=%0d err=%0b",
               step_cnt, pc, err, exp_steps, exp_pc, exp_err);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (exe_valid !== 0 || busy !== 0 || done !== 0 || err !== 0) begin
      errors++;
      $display("FAIL reset_ctrl: got valid=%0b busy=%0b done=%0b err=%0b, need all 0", exe_valid, busy, done, err);
    end
    checks++;
    if (pc !== 4'd0 || step_cnt !== 8'd0 || exe_opcode !== 4'd0 || exe_operand !== 4'd0) begin
      errors++;
      $display("FAIL reset_data: got pc=%0d step=%0d op=%h opd=%h, need all 0", pc, step_cnt, exe_opcode, exe_operand);
    end
  endtask

  task automatic test_basic();
    int dc, fv;
    do_reset();
    load_word(4'd0, 8'h05);
    load_word(4'd1, 8'h13);
    load_word(4'd2, 8'hF0);
    run_prog(100, dc, fv);
    checks++;
    if (fv != 2) begin
      errors++;
      $display("FAIL start_latency: got first valid at +%0d, need +2", fv);
    end
    checks++;
    if (step_cnt !== 8'd2 || pc !== 4'd2 || err !== 1'b0) begin
      errors++;
      $display("FAIL basic_final: got step=%0d pc=%0d err=%0b, need 2 2 0", step_cnt, pc, err);
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    load_word(4'd0, 8'h37);
    @(negedge clk);
    start = 1'b1;
    n = 0;
    do begin @(negedge clk); start = 1'b0; n++; end while (!exe_valid && n < 10);
    exe_ready = 1'b0;
    load_en = 1'b1; load_addr = 4'd1; load_instr = 8'h99;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (exe_valid !== 1'b1 || {exe_opcode, exe_operand} !== 8'h37 || step_cnt !== 8'd0) begin
        errors++;
        $display("FAIL bp_hold: got valid=%0b word=%h step=%0d, need 1 37 0", exe_valid, {exe_opcode, exe_operand}, step_cnt);
      end
      @(negedge clk);
      load_en = 1'b0;
    end
    exe_ready = 1'b1;
    @(negedge clk);
    exe_ready = 1'b0;
    checks++;
    if (exe_valid !== 1'b0 || step_cnt !== 8'd1) begin
      errors++;
      $display("FAIL bp_accept: got valid=%0b step=%0d, need 0 1", exe_valid, step_cnt);
    end
    n = 0;
    while (!done && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (done !== 1'b1 || step_cnt !== 8'd1 || pc !== 4'd1 || err !== 1'b0) begin
      errors++;
      $display("FAIL bp_final: got done=%0b step=%0d pc=%0d err=%0b, need 1 1 1 0", done, step_cnt, pc, err);
    end
  endtask

  task automatic test_jump_loop();
    int dc, fv;
    do_reset();
    load_word(4'd0, 8'h21);
    load_word(4'd1, 8'hE0);
    run_prog(100, dc, fv);
    checks++;
    if (step_cnt !== 8'd64 || err !== 1'b1) begin
      errors++;
      $display("FAIL watchdog: got step=%0d err=%0b, need 64 1", step_cnt, err);
    end
  endtask

  task automatic test_pure_jump();
    int dc, fv;
    do_reset();
    load_word(4'd0, 8'hE0);
    run_prog(100, dc, fv);
    checks++;
    if (dc != 17 || fv != -1 || err !== 1'b1 || step_cnt !== 8'd0) begin
      errors++;
      $display("FAIL jump_guard: got done at +%0d valid_at=%0d err=%0b step=%0d, need +17 -1 1 0", dc, fv, err, step_cnt);
    end
  endtask

  task automatic test_abort();
    int n;
    bit saw_done;
    do_reset();
    load_word(4'd0, 8'h45);
    load_word(4'd1, 8'h46);
    load_word(4'd2, 8'hF0);
    @(negedge clk);
    start = 1'b1;
    n = 0;
    do begin @(negedge clk); start = 1'b0; n++; end while (!exe_valid && n < 10);
    exe_ready = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    exe_ready = 1'b0;
    checks++;
    if (busy !== 0 || exe_valid !== 0 || step_cnt !== 8'd0 || err !== 0 || done !== 0) begin
      errors++;
      $display("FAIL abort_issue: got busy=%0b valid=%0b step=%0d err=%0b done=%0b, need 0 0 0 0 0", busy, exe_valid, step_cnt, err, done);
    end
    saw_done = 0;
    for (int k = 0; k < 4; k++) begin @(negedge clk); if (done || busy) saw_done = 1; end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort_quiet: got done/busy after abort, need idle");
    end
  endtask

  task automatic test_async_reset();
    int n, dc, fv;
    bit saw_done;
    do_reset();
    load_word(4'd0, 8'h12);
    load_word(4'd1, 8'h34);
    load_word(4'd2, 8'hF0);
    @(negedge clk);
    start = 1'b1;
    exe_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); start = 1'b0; n++; end while (!(exe_valid && step_cnt == 8'd1) && n < 20);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 0 || exe_valid !== 0 || pc !== 4'd0 || step_cnt !== 8'd0 || exe_opcode !== 4'd0) begin
      errors++;
      $display("FAIL async_rst: got busy=%0b valid=%0b pc=%0d step=%0d op=%h, need all 0", busy, exe_valid, pc, step_cnt, exe_opcode);
    end
    exe_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) tb_mem[i] = {STOP, 4'h0};
    saw_done = 0;
    for (int k = 0; k < 3; k++) begin @(negedge clk); if (done) saw_done = 1; end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL rst_no_done: got done after mid-run reset, need none");
    end
    run_prog(100, dc, fv);
    checks++;
    if (dc != 2 || fv != -1 || step_cnt !== 8'd0) begin
      errors++;
      $display("FAIL halt_mem: got done at +%0d valid_at=%0d step=%0d, need +2 -1 0", dc, fv, step_cnt);
    end
  endtask

  task automatic test_random();
    int dc, fv, r;
    logic [7:0] w;
    do_reset();
    for (int t = 0; t < 10; t++) begin
      for (int a = 0; a < 16; a++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      w = {STOP, 4'($urandom_range(0, 15))};
        else if (r == 1) w = {JMP, 4'($urandom_range(0, 15))};
        else             w = {4'($urandom_range(0, 13)), 4'($urandom_range(0, 15))};
        load_word(4'(a), w);
      end
      run_prog($urandom_range(30, 100), dc, fv);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_jump_loop();
    test_pure_jump();
    test_abort();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
